// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer feeding the IR register: holds the PC, runs a
// req/ready word read per instruction and pulses IR_Load once per fetched word.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              BranchValid,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemReady,
  input  logic [DATA_W-1:0] MemData,
  output logic [DATA_W-1:0] IR_In,
  output logic              IR_Load,
  output logic [ADDR_W-1:0] FetchPC,
  output logic [ADDR_W-1:0] PC
);

  typedef enum logic [1:0] {IDLE, REQ, LOAD, HOLD} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              req_q, req_d;
  logic              load_q, load_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] eff_pc;
  logic [ADDR_W-1:0] drop_pc;

  assign eff_pc  = BranchValid ? BranchTarget : pc_q;
  assign drop_pc = BranchValid ? BranchTarget : tgt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      pc_q   <= RESET_PC;
      addr_q <= '0;
      fpc_q  <= '0;
      tgt_q  <= '0;
      ir_q   <= '0;
      req_q  <= 1'b0;
      load_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      state  <= state_nx;
      pc_q   <= pc_d;
      addr_q <= addr_d;
      fpc_q  <= fpc_d;
      tgt_q  <= tgt_d;
      ir_q   <= ir_d;
      req_q  <= req_d;
      load_q <= load_d;
      pend_q <= pend_d;
    end
  end

  // LOAD returns through IDLE so consecutive fetches keep one idle clock
  // between the IR_Load pulse and the next request.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = Stall ? HOLD : REQ;
      REQ:     if (MemReady) state_nx = (pend_q || BranchValid) ? IDLE : LOAD;
      LOAD:    state_nx = Stall ? HOLD : IDLE;
      HOLD:    state_nx = Stall ? HOLD : REQ;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    addr_d = addr_q;
    fpc_d  = fpc_q;
    tgt_d  = tgt_q;
    ir_d   = ir_q;
    pend_d = pend_q;
    req_d  = 1'b0;
    load_d = 1'b0;
    case (state)
      REQ: begin
        req_d = 1'b1;
        if (!MemReady) begin
          if (BranchValid) begin
            pend_d = 1'b1;
            tgt_d  = BranchTarget;
          end
        end else if (pend_q || BranchValid) begin
          req_d  = 1'b0;
          pc_d   = drop_pc;
          pend_d = 1'b0;
        end else begin
          req_d  = 1'b0;
          ir_d   = MemData;
          fpc_d  = addr_q;
          load_d = 1'b1;
          pc_d   = pc_q + ADDR_W'(PC_STEP);
        end
      end
      default: begin
        pc_d = eff_pc;
        if (state_nx == REQ) begin
          req_d  = 1'b1;
          addr_d = eff_pc;
        end
      end
    endcase
  end

  assign MemReq  = req_q;
  assign MemAddr = addr_q;
  assign IR_In   = ir_q;
  assign IR_Load = load_q;
  assign FetchPC = fpc_q;
  assign PC      = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table on a RESET_PC=0x100
// instance plus hand sequences for IR capture and PC wrap-around.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, bv, rdy;
  logic [31:0] bt, data;
  logic        req, load;
  logic [31:0] addr, ir, fpc, pc;

  logic        w_rst, w_stall, w_bv, w_rdy;
  logic [31:0] w_bt, w_data;
  logic        w_req, w_load;
  logic [31:0] w_addr, w_ir, w_fpc, w_pc;

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0100), .PC_STEP(4)) u_dut (
    .Clk(clk), .Reset(rst), .Stall(stall), .BranchValid(bv), .BranchTarget(bt),
    .MemReq(req), .MemAddr(addr), .MemReady(rdy), .MemData(data),
    .IR_In(ir), .IR_Load(load), .FetchPC(fpc), .PC(pc)
  );

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) u_wrap (
    .Clk(clk), .Reset(w_rst), .Stall(w_stall), .BranchValid(w_bv), .BranchTarget(w_bt),
    .MemReq(w_req), .MemAddr(w_addr), .MemReady(w_rdy), .MemData(w_data),
    .IR_In(w_ir), .IR_Load(w_load), .FetchPC(w_fpc), .PC(w_pc)
  );

  assign w_data = w_addr ^ 32'hA5A5_A5A5;

  logic [31:0] ir_reg = '0;
  always @(posedge clk) if (load) ir_reg <= ir;

  typedef struct {
    logic        rst, stall, bv, rdy;
    logic [31:0] bt, data;
    logic        e_req, e_load;
    logic [31:0] e_addr, e_ir, e_fpc, e_pc;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [31:0] x(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  task automatic add(input logic r, s, b, input logic [31:0] t, input logic y,
                     input logic [31:0] d, input logic eq, input logic [31:0] ea,
                     input logic el, input logic [31:0] ei, ef, ep);
    vec_t v;
    v.rst = r; v.stall = s; v.bv = b; v.bt = t; v.rdy = y; v.data = d;
    v.e_req = eq; v.e_addr = ea; v.e_load = el; v.e_ir = ei; v.e_fpc = ef; v.e_pc = ep;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; bv = 1'b0; rdy = 1'b0; bt = '0; data = '0;
    w_rst = 1'b1; w_stall = 1'b0; w_bv = 1'b0; w_rdy = 1'b0; w_bt = '0;

    //   rst st bv bt           rdy data           req addr         ld ir             fpc          pc
    add(1, 0, 0, 32'h0,      0, 32'h0,        0, 32'h0,     0, 32'h0,        32'h0,     32'h100);
    add(1, 0, 0, 32'h0,      1, 32'h0,        0, 32'h0,     0, 32'h0,        32'h0,     32'h100);
    add(0, 0, 0, 32'h0,      1, 32'h0,        1, 32'h100,   0, 32'h0,        32'h0,     32'h100);
    add(0, 0, 0, 32'h0,      1, x(32'h100),   0, 32'h100,   1, x(32'h100),   32'h100,   32'h104);
    add(0, 0, 0, 32'h0,      1, 32'h0,        0, 32'h100,   0, x(32'h100),   32'h100,   32'h104);
    add(0, 0, 0, 32'h0,      1, 32'h0,        1, 32'h104,   0, x(32'h100),   32'h100,   32'h104);
    add(0, 0, 0, 32'h0,      1, x(32'h104),   0, 32'h104,   1, x(32'h104),   32'h104,   32'h108);
    add(0, 0, 0, 32'h0,      1, 32'h0,        0, 32'h104,   0, x(32'h104),   32'h104,   32'h108);
    add(0, 0, 0, 32'h0,      1, 32'h0,        1, 32'h108,   0, x(32'h104),   32'h104,   32'h108);
    add(0, 0, 0, 32'h0,      1, x(32'h108),   0, 32'h108,   1, x(32'h108),   32'h108,   32'h10C);
    add(0, 0, 0, 32'h0,      1, 32'h0,        0, 32'h108,   0, x(32'h108),   32'h108,   32'h10C);
    add(0, 0, 0, 32'h0,      0, 32'h0,        1, 32'h10C,   0, x(32'h108),   32'h108,   32'h10C);
    add(0, 0, 0, 32'h0,      0, 32'h0,        1, 32'h10C,   0, x(32'h108),   32'h108,   32'h10C);
    add(0, 0, 0, 32'h0,      0, 32'h0,        1, 32'h10C,   0, x(32'h108),   32'h108,   32'h10C);
    add(0, 1, 0, 32'h0,      0, 32'h0,        1, 32'h10C,   0, x(32'h108),   32'h108,   32'h10C);
    add(0, 1, 0, 32'h0,      0, 32'h0,        1, 32'h10C,   0, x(32'h108),   32'h108,   32'h10C);
    add(0, 0, 0, 32'h0,      0, 32'h0,        1, 32'h10C,   0, x(32'h108),   32'h108,   32'h10C);
    add(0, 0, 0, 32'h0,      1, x(32'h10C),   0, 32'h10C,   1, x(32'h10C),   32'h10C,   32'h110);
    add(0, 0, 0, 32'h0,      0, 32'h0,        0, 32'h10C,   0, x(32'h10C),   32'h10C,   32'h110);
    add(0, 0, 0, 32'h0,      0, 32'h0,        1, 32'h110,   0, x(32'h10C),   32'h10C,   32'h110);
    add(0, 0, 1, 32'h2000,   0, 32'h0,        1, 32'h110,   0, x(32'h10C),   32'h10C,   32'h110);
    add(0, 0, 0, 32'h0,      0, 32'h0,        1, 32'h110,   0, x(32'h10C),   32'h10C,   32'h110);
    add(0, 0, 0, 32'h0,      1, x(32'h110),   0, 32'h110,   0, x(32'h10C),   32'h10C,   32'h2000);
    add(0, 0, 0, 32'h0,      0, 32'h0,        1, 32'h2000,  0, x(32'h10C),   32'h10C,   32'h2000);
    add(0, 0, 0, 32'h0,      1, x(32'h2000),  0, 32'h2000,  1, x(32'h2000),  32'h2000,  32'h2004);
    add(0, 1, 0, 32'h0,      0, 32'h0,        0, 32'h2000,  0, x(32'h2000),  32'h2000,  32'h2004);
    add(0, 1, 0, 32'h0,      0, 32'h0,        0, 32'h2000,  0, x(32'h2000),  32'h2000,  32'h2004);
    add(0, 1, 0, 32'h0,      0, 32'h0,        0, 32'h2000,  0, x(32'h2000),  32'h2000,  32'h2004);
    add(0, 1, 1, 32'h40,     0, 32'h0,        0, 32'h2000,  0, x(32'h2000),  32'h2000,  32'h40);
    add(0, 0, 0, 32'h0,      0, 32'h0,        1, 32'h40,    0, x(32'h2000),  32'h2000,  32'h40);
    add(0, 0, 0, 32'h0,      1, x(32'h40),    0, 32'h40,    1, x(32'h40),    32'h40,    32'h44);
    add(0, 0, 0, 32'h0,      0, 32'h0,        0, 32'h40,    0, x(32'h40),    32'h40,    32'h44);
    add(0, 0, 0, 32'h0,      0, 32'h0,        1, 32'h44,    0, x(32'h40),    32'h40,    32'h44);
    add(0, 0, 1, 32'h80,     1, x(32'h44),    0, 32'h44,    0, x(32'h40),    32'h40,    32'h80);
    add(0, 0, 0, 32'h0,      0, 32'h0,        1, 32'h80,    0, x(32'h40),    32'h40,    32'h80);
    add(0, 0, 1, 32'h300,    0, 32'h0,        1, 32'h80,    0, x(32'h40),    32'h40,    32'h80);
    add(0, 0, 1, 32'h500,    1, x(32'h80),    0, 32'h80,    0, x(32'h40),    32'h40,    32'h500);
    add(0, 0, 0, 32'h0,      0, 32'h0,        1, 32'h500,   0, x(32'h40),    32'h40,    32'h500);
    add(1, 0, 0, 32'h0,      0, 32'h0,        0, 32'h0,     0, 32'h0,        32'h0,     32'h100);
    add(0, 1, 0, 32'h0,      1, 32'hDEADBEEF, 0, 32'h0,     0, 32'h0,        32'h0,     32'h100);
    add(0, 0, 0, 32'h0,      1, 32'hDEADBEEF, 1, 32'h100,   0, 32'h0,        32'h0,     32'h100);
    add(0, 0, 0, 32'h0,      1, x(32'h100),   0, 32'h100,   1, x(32'h100),   32'h100,   32'h104);

    foreach (vq[i]) begin
      rst = vq[i].rst; stall = vq[i].stall; bv = vq[i].bv; bt = vq[i].bt;
      rdy = vq[i].rdy; data = vq[i].data;
      @(posedge clk); #1;
      n_vec++;
      if (req !== vq[i].e_req || addr !== vq[i].e_addr || load !== vq[i].e_load ||
          ir !== vq[i].e_ir || fpc !== vq[i].e_fpc || pc !== vq[i].e_pc) begin
        n_bad++;
        $display("FAIL vec%0d: got req=%b addr=%h load=%b ir=%h fpc=%h pc=%h expected req=%b addr=%h load=%b ir=%h fpc=%h pc=%h",
                 i, req, addr, load, ir, fpc, pc, vq[i].e_req, vq[i].e_addr, vq[i].e_load,
                 vq[i].e_ir, vq[i].e_fpc, vq[i].e_pc);
      end
    end

    // IR register downstream captures the pulsed word
    rst = 1'b0; stall = 1'b1; bv = 1'b0; rdy = 1'b0; data = '0;
    @(posedge clk); #1;
    check("ir_register_out", ir_reg, x(32'h100));
    check("load_single_pulse", {31'b0, load}, 32'h0);

    // Wrap-around instance
    repeat (2) @(posedge clk);
    #1;
    check("wrap_reset_pc", w_pc, 32'hFFFF_FFFC);
    check("wrap_reset_req", {31'b0, w_req}, 32'h0);
    w_rst = 1'b0; w_rdy = 1'b1;
    begin
      int unsigned k;
      for (k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        if (w_load) break;
      end
      check("wrap_load_seen", {31'b0, w_load}, 32'h1);
    end
    check("wrap_fetch_pc", w_fpc, 32'hFFFF_FFFC);
    check("wrap_ir", w_ir, 32'h5A5A_5A59);
    check("wrap_pc", w_pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
